// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin launcher in front of the MII UDP frame transmitter.
// Grants one requester, pulses tx_start, waits for tx_done or timeout, then holds the IFG.
module udp_tx_sched #(
    parameter int N_REQ      = 3,
    parameter int IFG_CYCLES = 24,
    parameter int TIMEOUT    = 4095
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [N_REQ-1:0]    req,
    input  logic [32*N_REQ-1:0] req_cmd,
    output logic [N_REQ-1:0]    grant,
    output logic [31:0]         tx_cmd,
    output logic                tx_start,
    input  logic                tx_done,
    output logic                busy,
    output logic                timeout_err,
    output logic [15:0]         frame_cnt
);
    localparam int GAP_LEN = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int GW      = $clog2(GAP_LEN + 1);
    localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t           state;
    logic [PW-1:0]    last;
    logic [PW-1:0]    win;
    logic [PW-1:0]    idx;
    logic             found;
    logic [N_REQ-1:0] win_oh;
    logic [31:0]      win_cmd;
    logic [TW-1:0]    tmo;
    logic [GW-1:0]    gap_cnt;

    // Scan starts just past the last winner, so a fresh grant goes to the back of the line.
    always_comb begin
        win     = last;
        idx     = '0;
        found   = 1'b0;
        win_oh  = '0;
        win_cmd = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = PW'((int'(last) + i) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        for (int n = 0; n < N_REQ; n++) begin
            if (PW'(n) == win) begin
                win_oh[n] = 1'b1;
                win_cmd   = req_cmd[32*n +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= IDLE;
            grant       <= '0;
            tx_cmd      <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
            last        <= PW'(N_REQ - 1);
            tmo         <= '0;
            gap_cnt     <= '0;
        end else begin
            grant       <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= win_oh;
                        tx_cmd   <= win_cmd;
                        last     <= win;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    tmo   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving on the expiry cycle still counts as a good frame.
                    if (tx_done) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_LEN - 1)) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_sched.sv
// Bench for udp_tx_sched: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed grant order, spacing and counts.
module tb_udp_tx_sched;
    localparam int N   = 3;
    localparam int IFG = 24;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            clr;
    logic [N-1:0]    req;
    logic [32*N-1:0] req_cmd;
    logic            tx_done;
    logic [N-1:0]    grant;
    logic [31:0]     tx_cmd;
    logic            tx_start;
    logic            busy;
    logic            timeout_err;
    logic [15:0]     frame_cnt;

    always #5 clk = ~clk;

    udp_tx_sched #(.N_REQ(N), .IFG_CYCLES(IFG), .TIMEOUT(TMO)) dut (
        .clk(clk), .clr(clr), .req(req), .req_cmd(req_cmd),
        .grant(grant), .tx_cmd(tx_cmd), .tx_start(tx_start),
        .tx_done(tx_done), .busy(busy), .timeout_err(timeout_err),
        .frame_cnt(frame_cnt)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    bit drop_on = 1'b0;

    // Reference model: launch time and gap-entry time drive everything.
    bit          m_busy;
    int          t_launch;
    int          t_gap;
    int          m_last;
    logic [N-1:0] m_grant;
    logic [31:0] m_cmd;
    bit          m_start;
    bit          m_terr;
    logic [15:0] m_frames;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_step();
        int w;
        m_grant = '0;
        m_start = 1'b0;
        m_terr  = 1'b0;
        if (clr) begin
            m_busy   = 1'b0;
            m_cmd    = '0;
            m_frames = '0;
            m_last   = N - 1;
        end else if (!m_busy) begin
            w = -1;
            for (int i = 1; i <= N; i++) begin
                int j = (m_last + i) % N;
                if (w < 0 && req[j]) w = j;
            end
            if (w >= 0) begin
                m_last     = w;
                m_grant[w] = 1'b1;
                m_cmd      = req_cmd[32*w +: 32];
                m_start    = 1'b1;
                m_busy     = 1'b1;
                t_launch   = cyc;
                t_gap      = -1;
            end
        end else if (cyc - 1 != t_launch) begin
            if (t_gap < 0) begin
                if (tx_done) begin
                    m_frames = m_frames + 16'd1;
                    t_gap = cyc;
                end else if (cyc - 1 - t_launch == TMO) begin
                    m_terr = 1'b1;
                    t_gap = cyc;
                end
            end else if (cyc - t_gap == IFG) begin
                m_busy = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        chk("grant", 32'(grant), 32'(m_grant));
        chk("tx_cmd", tx_cmd, m_cmd);
        chk("tx_start", 32'(tx_start), 32'(m_start));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
        if (drop_on) req = req & ~grant;
    endtask

    task automatic wait_grant(output logic [N-1:0] g, output int e);
        int n = 0;
        do begin
            tick();
            n++;
        end while (grant == '0 && n < 200);
        chk("grant_wait", 32'(grant != '0), 32'd1);
        g = grant;
        e = cyc;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic frame(input int wl, output logic [N-1:0] g, output int e);
        wait_grant(g, e);
        repeat (wl) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        logic [N-1:0] g[4];
        int           e[4];
        int           l0;

        clr     = 1'b1;
        req     = '0;
        req_cmd = {32'hC3C30003, 32'hB2B20002, 32'hA5A50001};
        tx_done = 1'b0;
        tick();
        tick();
        clr = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frames", 32'(frame_cnt), 32'd0);
        chk("rst_cmd", tx_cmd, 32'd0);

        // single frame, done after 12 WAIT cycles
        drop_on = 1'b1;
        req = 3'b001;
        tick();
        l0 = cyc;
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_start", 32'(tx_start), 32'd1);
        chk("t1_cmd", tx_cmd, 32'hA5A50001);
        repeat (12) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t1_frames", 32'(frame_cnt), 32'd1);
        repeat (23) tick();
        chk("t1_busy_gap", 32'(busy), 32'd1);
        tick();
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_len", 32'(cyc - l0), 32'd37);

        // all three requesting, each drops on grant
        clr = 1'b1;
        tick();
        clr = 1'b0;
        req = 3'b111;
        for (int k = 0; k < 3; k++) frame(4, g[k], e[k]);
        chk("t2_g0", 32'(g[0]), 32'd1);
        chk("t2_g1", 32'(g[1]), 32'd2);
        chk("t2_g2", 32'(g[2]), 32'd4);
        chk("t2_cmd", tx_cmd, 32'hC3C30003);
        chk("t2_sp1", 32'(e[1] - e[0]), 32'd30);
        chk("t2_sp2", 32'(e[2] - e[1]), 32'd30);
        wait_idle();

        // two requesters held forever, instant done
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drop_on = 1'b0;
        req = 3'b011;
        for (int k = 0; k < 4; k++) frame(1, g[k], e[k]);
        req = '0;
        drop_on = 1'b1;
        chk("t3_g0", 32'(g[0]), 32'd1);
        chk("t3_g1", 32'(g[1]), 32'd2);
        chk("t3_g2", 32'(g[2]), 32'd1);
        chk("t3_g3", 32'(g[3]), 32'd2);
        chk("t3_sp", 32'(e[3] - e[2]), 32'd27);
        wait_idle();
        chk("t3_frames", 32'(frame_cnt), 32'd4);

        // timeout, then a request posted during WAIT
        req = 3'b001;
        wait_grant(g[0], l0);
        repeat (16) tick();
        chk("t4_no_err", 32'(timeout_err), 32'd0);
        req = 3'b100;
        tick();
        chk("t4_err", 32'(timeout_err), 32'd1);
        chk("t4_frames", 32'(frame_cnt), 32'd4);
        tick();
        chk("t4_err_pulse", 32'(timeout_err), 32'd0);
        wait_grant(g[1], e[1]);
        chk("t4_grant", 32'(g[1]), 32'd4);
        chk("t4_delay", 32'(e[1] - l0), 32'd42);
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_idle();

        // done on the expiry cycle, then stray done in IDLE
        req = 3'b010;
        wait_grant(g[0], l0);
        repeat (16) tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("t5_no_err", 32'(timeout_err), 32'd0);
        chk("t5_frames", 32'(frame_cnt), 32'd6);
        wait_idle();
        tx_done = 1'b1;
        repeat (2) tick();
        tx_done = 1'b0;
        tick();
        chk("t5_stray", 32'(frame_cnt), 32'd6);
        chk("t5_idle", 32'(busy), 32'd0);

        // clear during WAIT
        req = 3'b001;
        wait_grant(g[0], l0);
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_cmd", tx_cmd, 32'd0);
        chk("t6_frames", 32'(frame_cnt), 32'd0);
        chk("t6_terr", 32'(timeout_err), 32'd0);
        repeat (20) tick();

        // frame counter wrap
        force dut.frame_cnt = 16'hFFFE;
        m_frames = 16'hFFFE;
        tick();
        release dut.frame_cnt;
        req = 3'b010;
        frame(2, g[0], e[0]);
        chk("t6_ffff", 32'(frame_cnt), 32'h0000FFFF);
        wait_idle();
        req = 3'b100;
        frame(2, g[1], e[1]);
        chk("t6_wrap", 32'(frame_cnt), 32'd0);
        wait_idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
